// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers and end-of-range mode encodings
// for the Gray-code counter family.
package gray_pkg;

  // Widest counter the helper functions cover; callers zero-extend into it.
  localparam int MAX_W = 32;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unchanged, so one
  // fixed-width routine serves every counter width up to MAX_W.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [MAX_W-1:0] gray_ext;
  logic [MAX_W-1:0] bin_ext;

  always_comb begin
    gray_ext = MAX_W'(gray_i);
    bin_ext  = gray2bin(gray_ext);
    bin_o    = bin_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: up/down, enable, parallel Gray load,
// wrap or saturate at the range ends, registered terminal-count flag.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_end;
  logic [MAX_W-1:0] gray_ext;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray_i (load_gray),
    .bin_o  (load_bin)
  );

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    at_end = up ? (cnt_q == CNT_MAX) : (cnt_q == CNT_MIN);

    if (load) begin
      cnt_d = load_bin;
    end else if (en) begin
      if (at_end) begin
        tc_d = 1'b1;
        if (SAT == MODE_SAT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = up ? CNT_MIN : CNT_MAX;
        end
      end else begin
        cnt_d = up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
      end
    end

    // Gray is encoded from the next binary state so the port is a flop.
    gray_ext = bin2gray(MAX_W'(cnt_d));
    gray_d   = gray_ext[WIDTH-1:0];
  end

  always_ff @(negedge clk or posedge preset) begin
    if (preset) begin
      cnt_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign gray = gray_q;
  assign bin  = cnt_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: wrap and saturate instances driven in parallel,
// checked each edge against an arithmetic model plus literal pins.
module tb_gray_counter_n;

  localparam int W    = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b1;
  logic         preset = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_gray = '0;

  logic [W-1:0] gray_w, bin_w, conv_w;
  logic [W-1:0] gray_s, bin_s, conv_s;
  logic         tc_w, tc_s;

  int tests = 0;
  int fails = 0;
  int m_w = 0;
  int m_s = 0;
  bit t_w = 1'b0;
  bit t_s = 1'b0;

  logic [W-1:0] seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0111, 4'b0101, 4'b0100, 4'b1100,
                             4'b1101, 4'b1111, 4'b1110, 4'b1010,
                             4'b1011, 4'b1001, 4'b1000, 4'b0000};

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(W), .SAT(1'b0)) dut_w (
    .clk(clk), .preset(preset), .en(en), .up(up), .load(load),
    .load_gray(load_gray), .gray(gray_w), .bin(bin_w), .tc(tc_w)
  );

  gray_counter_n #(.WIDTH(W), .SAT(1'b1)) dut_s (
    .clk(clk), .preset(preset), .en(en), .up(up), .load(load),
    .load_gray(load_gray), .gray(gray_s), .bin(bin_s), .tc(tc_s)
  );

  gray2bin_conv #(.WIDTH(W)) chk_conv_w (.gray_i(gray_w), .bin_o(conv_w));
  gray2bin_conv #(.WIDTH(W)) chk_conv_s (.gray_i(gray_s), .bin_o(conv_s));

  // Decode by search: the binary value whose Gray code matches.
  function automatic int model_g2b(input int g);
    for (int b = 0; b <= MAXV; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(inout int m, inout bit t, input bit sat);
    if (load) begin
      m = model_g2b(int'(load_gray));
      t = 1'b0;
    end else if (en) begin
      if (up) begin
        if (m == MAXV) begin
          t = 1'b1;
          m = sat ? MAXV : 0;
        end else begin
          m = m + 1;
          t = 1'b0;
        end
      end else begin
        if (m == 0) begin
          t = 1'b1;
          m = sat ? 0 : MAXV;
        end else begin
          m = m - 1;
          t = 1'b0;
        end
      end
    end else begin
      t = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("w.gray", int'(gray_w), m_w ^ (m_w >> 1));
    chk("w.bin",  int'(bin_w),  m_w);
    chk("w.tc",   int'(tc_w),   int'(t_w));
    chk("w.conv", int'(bin_w),  int'(conv_w));
    chk("s.gray", int'(gray_s), m_s ^ (m_s >> 1));
    chk("s.bin",  int'(bin_s),  m_s);
    chk("s.tc",   int'(tc_s),   int'(t_s));
    chk("s.conv", int'(bin_s),  int'(conv_s));
  endtask

  // Drive between edges, let one falling edge happen, then check.
  task automatic cycle(input bit e, input bit u, input bit l, input logic [W-1:0] lg);
    logic [W-1:0] pw;
    logic [W-1:0] ps;
    int ow;
    int os;
    pw = gray_w;
    ps = gray_s;
    ow = m_w;
    os = m_s;
    en = e;
    up = u;
    load = l;
    load_gray = lg;
    @(negedge clk);
    model_step(m_w, t_w, 1'b0);
    model_step(m_s, t_s, 1'b1);
    #1;
    compare_all();
    if (e && !l) begin
      chk("w.onebit", $countones(pw ^ gray_w), (ow != m_w) ? 1 : 0);
      chk("s.onebit", $countones(ps ^ gray_s), (os != m_s) ? 1 : 0);
    end
  endtask

  task automatic do_preset();
    preset = 1'b1;
    #1;
    m_w = 0; t_w = 1'b0;
    m_s = 0; t_s = 1'b0;
    compare_all();
    #1;
    preset = 1'b0;
  endtask

  initial begin
    #1;
    compare_all();
    chk("reset.gray", int'(gray_w), 0);
    #2;
    preset = 1'b0;

    // Full up sweep with wrap
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'b0000);
      chk("seq", int'(gray_w), int'(seq[i]));
      chk("seq.tc", int'(tc_w), (i == 15) ? 1 : 0);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    chk("idle.tc", int'(tc_w), 0);

    // Down from zero
    do_preset();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("down.gray", int'(gray_w), 4'b1000);
    chk("down.bin",  int'(bin_w), 15);
    chk("down.tc",   int'(tc_w), 1);
    chk("down.sat.gray", int'(gray_s), 0);
    chk("down.sat.tc",   int'(tc_s), 1);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("down2.gray", int'(gray_w), 4'b1001);
    chk("down2.bin",  int'(bin_w), 14);
    chk("down2.tc",   int'(tc_w), 0);

    // Saturate at the top after a load
    cycle(1'b0, 1'b1, 1'b1, 4'b1000);
    chk("ld.bin", int'(bin_s), 15);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'b0000);
      chk("sat.gray", int'(gray_s), 4'b1000);
      chk("sat.tc",   int'(tc_s), 1);
    end
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("sat.back.gray", int'(gray_s), 4'b1001);
    chk("sat.back.tc",   int'(tc_s), 0);

    // Load beats enable
    cycle(1'b1, 1'b1, 1'b1, 4'b0110);
    chk("ldwin.bin",  int'(bin_w), 4);
    chk("ldwin.gray", int'(gray_w), 4'b0110);
    chk("ldwin.tc",   int'(tc_w), 0);

    // Async preset between edges
    do_preset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0000);
    chk("pre7.bin", int'(bin_w), 7);
    do_preset();
    chk("async.gray", int'(gray_w), 0);
    chk("async.bin",  int'(bin_w), 0);
    cycle(1'b1, 1'b1, 1'b0, 4'b0000);
    chk("post.gray", int'(gray_w), 4'b0001);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0,
            ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
